// File: rtl/alu_div_seq_pkg.sv
// alu_div_seq_pkg: ALU opcodes and sequencer state encodings shared by the
// divide sequencer, its ALU bus interface and anything that models the ALU.
// Optional build macro: ALU_DIV_FLAG_PRESERVE_EN adds the flag save/restore states.
package alu_div_seq_pkg;

  // ALU opcodes used by the divide sequencer.
  localparam logic [4:0] ALU_OP_SUB  = 5'd3;
  localparam logic [4:0] ALU_OP_ROLC = 5'd19;
  localparam logic [4:0] ALU_OP_CLC  = 5'd23;
  localparam logic [4:0] ALU_OP_STF  = 5'd29;
  localparam logic [4:0] ALU_OP_RSF  = 5'd30;

  // Sequencer states. *_I states issue an ALU op, *_C states capture its result.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLC    = 4'd1,
    S_ROLQ_I = 4'd2,
    S_ROLQ_C = 4'd3,
    S_ROLR_I = 4'd4,
    S_ROLR_C = 4'd5,
    S_SUB_I  = 4'd6,
    S_SUB_C  = 4'd7,
`ifdef ALU_DIV_FLAG_PRESERVE_EN
    S_DONE   = 4'd8,
    S_SAVE_I = 4'd9,
    S_SAVE_C = 4'd10,
    S_REST_I = 4'd11
`else
    S_DONE   = 4'd8
`endif
  } state_t;

endpackage

// File: rtl/alu_div_seq_if.sv
// alu_div_seq_if: operand/opcode bus between the divide sequencer (master)
// and the shared ALU (slave).
//
// Handshake: alu_execute qualifies alu_op/alu_A/alu_B for exactly the cycle it
// is high; the ALU accepts unconditionally (no ready/back-pressure) and presents
// the result on alu_out/alu_C in the following cycle. While alu_execute is low
// the master drives op/A/B to zero. alu_own selects the sequencer onto the ALU
// input mux for the whole duration of a division.
interface alu_div_seq_if #(
  parameter int BITS = 16
);
  logic            alu_own;
  logic [4:0]      alu_op;
  logic [BITS-1:0] alu_A;
  logic [BITS-1:0] alu_B;
  logic            alu_execute;
  logic [BITS-1:0] alu_out;
  logic            alu_C;

  modport master (
    output alu_own, alu_op, alu_A, alu_B, alu_execute,
    input  alu_out, alu_C
  );

  modport slave (
    input  alu_own, alu_op, alu_A, alu_B, alu_execute,
    output alu_out, alu_C
  );
endinterface

// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle unsigned BITS/BITS restoring divider that borrows
// the shared ALU for every arithmetic step (clear-carry, rotate-through-carry,
// subtract). Seven cycles per quotient bit; divide-by-zero answers in one cycle.
// Optional build macro: ALU_DIV_FLAG_PRESERVE_EN saves the ALU flags before the
// division and restores them afterwards so the CPU sees them unchanged.
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int CNT_W = 5
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero,
  alu_div_seq_if.master   alu,
  output state_t          state_dbg
);

  state_t          state;
  logic [BITS-1:0] d_reg;    // divisor
  logic [BITS-1:0] q_reg;    // dividend shifting out, quotient shifting in
  logic [BITS-1:0] r_reg;    // partial remainder
  logic [BITS-1:0] rs_reg;   // partial remainder after the left shift
  logic            ovf;      // bit shifted out of the remainder: true value >= 2^BITS
  logic [CNT_W-1:0] cnt;
`ifdef ALU_DIV_FLAG_PRESERVE_EN
  logic [2:0]      flags_sav;
`endif

  // The ALU reports borrow on alu_C after SUB; the trial subtraction is kept
  // when there was no borrow, or when the shifted remainder overflowed BITS
  // (then it is certainly >= divisor and the wrapped difference is exact).
  logic            sub_ok;
  logic [BITS-1:0] q_upd;
  logic [BITS-1:0] r_upd;
  logic            last_bit;

  assign sub_ok   = ovf | ~alu.alu_C;
  assign q_upd    = {q_reg[BITS-1:1], sub_ok};
  assign r_upd    = sub_ok ? alu.alu_out : rs_reg;
  assign last_bit = (cnt == CNT_W'(BITS-1));

  assign alu.alu_own = busy;
  assign state_dbg   = state;

  // Sequencer FSM: state, working registers and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      quotient        <= '0;
      remainder       <= '0;
      div_by_zero     <= 1'b0;
      d_reg           <= '0;
      q_reg           <= '0;
      r_reg           <= '0;
      rs_reg          <= '0;
      ovf             <= 1'b0;
      cnt             <= '0;
`ifdef ALU_DIV_FLAG_PRESERVE_EN
      flags_sav       <= '0;
`endif
      alu.alu_execute <= 1'b0;
      alu.alu_op      <= '0;
      alu.alu_A       <= '0;
      alu.alu_B       <= '0;
    end else begin
      // Issue outputs are one-cycle; states that issue override these.
      done            <= 1'b0;
      alu.alu_execute <= 1'b0;
      alu.alu_op      <= '0;
      alu.alu_A       <= '0;
      alu.alu_B       <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              d_reg       <= divisor;
              q_reg       <= dividend;
              r_reg       <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              alu.alu_execute <= 1'b1;
`ifdef ALU_DIV_FLAG_PRESERVE_EN
              state      <= S_SAVE_I;
              alu.alu_op <= ALU_OP_STF;
`else
              state      <= S_CLC;
              alu.alu_op <= ALU_OP_CLC;
`endif
            end
          end
        end

`ifdef ALU_DIV_FLAG_PRESERVE_EN
        S_SAVE_I: state <= S_SAVE_C;

        S_SAVE_C: begin
          flags_sav       <= alu.alu_out[2:0];
          state           <= S_CLC;
          alu.alu_execute <= 1'b1;
          alu.alu_op      <= ALU_OP_CLC;
        end

        S_REST_I: begin
          state     <= S_DONE;
          done      <= 1'b1;
          quotient  <= q_reg;
          remainder <= r_reg;
        end
`endif

        // Carry is clear: shift Q left, its MSB lands in the carry.
        S_CLC: begin
          state           <= S_ROLQ_I;
          alu.alu_execute <= 1'b1;
          alu.alu_op      <= ALU_OP_ROLC;
          alu.alu_B       <= q_reg;
        end

        S_ROLQ_I: state <= S_ROLQ_C;

        // Shift R left taking in the old Q MSB from the carry.
        S_ROLQ_C: begin
          q_reg           <= alu.alu_out;
          state           <= S_ROLR_I;
          alu.alu_execute <= 1'b1;
          alu.alu_op      <= ALU_OP_ROLC;
          alu.alu_B       <= r_reg;
        end

        S_ROLR_I: state <= S_ROLR_C;

        // Trial subtract the divisor from the shifted remainder.
        S_ROLR_C: begin
          rs_reg          <= alu.alu_out;
          ovf             <= alu.alu_C;
          state           <= S_SUB_I;
          alu.alu_execute <= 1'b1;
          alu.alu_op      <= ALU_OP_SUB;
          alu.alu_A       <= alu.alu_out;
          alu.alu_B       <= d_reg;
        end

        S_SUB_I: state <= S_SUB_C;

        S_SUB_C: begin
          q_reg <= q_upd;
          r_reg <= r_upd;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
`ifdef ALU_DIV_FLAG_PRESERVE_EN
            state           <= S_REST_I;
            alu.alu_execute <= 1'b1;
            alu.alu_op      <= ALU_OP_RSF;
            alu.alu_B       <= {{(BITS-3){1'b0}}, flags_sav};
`else
            state     <= S_DONE;
            done      <= 1'b1;
            quotient  <= q_upd;
            remainder <= r_upd;
`endif
          end else begin
            state           <= S_CLC;
            alu.alu_execute <= 1'b1;
            alu.alu_op      <= ALU_OP_CLC;
          end
        end

        // A start seen here is deliberately ignored.
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: bench for alu_div_seq with a behavioural shared-ALU model.
// Optional build macro: ALU_DIV_FLAG_PRESERVE_EN (flag save/restore build).
module tb_alu_div_seq;
  import alu_div_seq_pkg::*;

`ifdef ALU_DIV_FLAG_PRESERVE_EN
  localparam int LAT = 7 * 16 + 4;
`else
  localparam int LAT = 7 * 16 + 1;
`endif

  logic        CLK;
  logic        RSTb;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  state_t      state_dbg;

  alu_div_seq_if #(.BITS(16)) alu_bus ();

  alu_div_seq #(.BITS(16), .CNT_W(5)) dut (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .alu         (alu_bus),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- shared ALU model ----------------
  // Flags: C = carry (ROLC) / borrow (SUB). STF reads {S,C,Z}; RSF loads it.
  logic       s_f = 1'b0;
  logic       c_f = 1'b0;
  logic       z_f = 1'b0;
  logic       flag_load = 1'b0;
  logic [2:0] flag_val = 3'b000;
  logic [15:0] alu_res;

  assign alu_bus.alu_C = c_f;

  always @(posedge CLK) begin
    if (flag_load) begin
      {s_f, c_f, z_f} <= flag_val;
    end else if (alu_bus.alu_execute) begin
      case (alu_bus.alu_op)
        ALU_OP_CLC: begin
          c_f <= 1'b0;
          alu_bus.alu_out <= 16'h0000;
        end
        ALU_OP_ROLC: begin
          alu_res = {alu_bus.alu_B[14:0], c_f};
          alu_bus.alu_out <= alu_res;
          c_f <= alu_bus.alu_B[15];
          z_f <= (alu_res == 16'h0000);
          s_f <= alu_res[15];
        end
        ALU_OP_SUB: begin
          alu_res = alu_bus.alu_A - alu_bus.alu_B;
          alu_bus.alu_out <= alu_res;
          c_f <= (alu_bus.alu_A < alu_bus.alu_B);
          z_f <= (alu_res == 16'h0000);
          s_f <= alu_res[15];
        end
        ALU_OP_STF: alu_bus.alu_out <= {13'd0, s_f, c_f, z_f};
        ALU_OP_RSF: {s_f, c_f, z_f} <= alu_bus.alu_B[2:0];
        default:    alu_bus.alu_out <= 16'h0000;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {div_by_zero, quotient, remainder}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // ---------------- driver ----------------
  // Start a division at a negedge (cycle 0), follow it to done, compare.
  // glitch=1 pulses start with other operands at cycles 1, 50 and the done cycle.
  task automatic run_div(input logic [15:0] dvd, input logic [15:0] dvs,
                         input logic [32:0] exp_w, input int exp_lat, input bit glitch);
    int n;
    bit seen, busy_ok, own_ok, quiet_ok;
    logic [32:0] want;
    exp_q.push_back(exp_w);
    @(negedge CLK);
    start = 1'b1; dividend = dvd; divisor = dvs;
    n = 0; seen = 0; busy_ok = 1; own_ok = 1; quiet_ok = 1;
    while (!seen && n < 400) begin
      @(negedge CLK);
      n++;
      if (glitch && (n == 1 || n == 50 || n == exp_lat)) begin
        start = 1'b1; dividend = 16'd9; divisor = 16'd3;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busy_ok = 0;
      if (alu_bus.alu_own !== busy) own_ok = 0;
      if (dvs == 16'd0 && alu_bus.alu_execute !== 1'b0) quiet_ok = 0;
      if (alu_bus.alu_execute === 1'b0 &&
          {alu_bus.alu_op, alu_bus.alu_A, alu_bus.alu_B} !== 37'd0) quiet_ok = 0;
      if (done === 1'b1) seen = 1;
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    check("done_cycle", n, exp_lat);
    check("busy_while_running", {63'd0, busy_ok}, 64'd1);
    check("alu_own_eq_busy", {63'd0, own_ok}, 64'd1);
    check("alu_bus_quiet", {63'd0, quiet_ok}, 64'd1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
    check("result", {div_by_zero, quotient, remainder}, want);
    @(negedge CLK);
    start = 1'b0;
    check("idle_after_done", {busy, done}, 2'b00);
    check("result_held", {div_by_zero, quotient, remainder}, want);
  endtask

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] a, b;

    vecs[0] = '{16'd100,    16'd7,      16'd14,     16'd2,      1'b0};
    vecs[1] = '{16'hFFFF,   16'h8001,   16'd1,      16'h7FFE,   1'b0};
    vecs[2] = '{16'hFFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0};
    vecs[3] = '{16'd5,      16'd0,      16'hFFFF,   16'd5,      1'b1};
    vecs[4] = '{16'd9,      16'd3,      16'd3,      16'd0,      1'b0};
    vecs[5] = '{16'd0,      16'd5,      16'd0,      16'd0,      1'b0};
    vecs[6] = '{16'd1,      16'hFFFF,   16'd0,      16'd1,      1'b0};
    vecs[7] = '{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,      1'b0};
    vecs[8] = '{16'h1234,   16'h0010,   16'h0123,   16'd4,      1'b0};
    vecs[9] = '{16'd0,      16'd0,      16'hFFFF,   16'd0,      1'b1};

    // reset
    RSTb = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_flags", {busy, done, div_by_zero, alu_bus.alu_execute, alu_bus.alu_own}, 5'b00000);
    check("reset_results", {quotient, remainder}, 32'd0);
    check("reset_state", state_dbg, S_IDLE);
    RSTb = 1'b1;

    // table vectors
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].dvd, vecs[i].dvs, {vecs[i].dbz, vecs[i].q, vecs[i].r},
              (vecs[i].dvs == 16'd0) ? 1 : LAT, 1'b0);
    end

    // start pulses while busy and in the done cycle are ignored
    run_div(16'd100, 16'd7, {1'b0, 16'd14, 16'd2}, LAT, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      check("no_second_done", {busy, done}, 2'b00);
    end

    // reset in the middle of a division
    @(negedge CLK);
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    RSTb = 1'b0;
    @(negedge CLK);
    check("abort_state", state_dbg, S_IDLE);
    check("abort_flags", {busy, done, div_by_zero, alu_bus.alu_execute, alu_bus.alu_own}, 5'b00000);
    check("abort_results", {quotient, remainder}, 32'd0);
    check("abort_alu_bus", {alu_bus.alu_op, alu_bus.alu_A, alu_bus.alu_B}, 37'd0);
    RSTb = 1'b1;
    run_div(16'd9, 16'd3, {1'b0, 16'd3, 16'd0}, LAT, 1'b0);

    // random operands, expected from the language's own / and %
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = (i < 3) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(1, 65535));
      run_div(a, b, {1'b0, a / b, a % b}, LAT, 1'b0);
    end

`ifdef ALU_DIV_FLAG_PRESERVE_EN
    // flags must survive a division
    @(negedge CLK);
    flag_load = 1'b1; flag_val = 3'b110;
    @(negedge CLK);
    flag_load = 1'b0;
    run_div(16'd100, 16'd7, {1'b0, 16'd14, 16'd2}, LAT, 1'b0);
    check("flags_preserved", {s_f, c_f, z_f}, 3'b110);
`endif

    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
